// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the SRAM-like instruction bus
// (req/addr_ok/data_ok), buffers a returned word while IF/ID is stalled, and
// applies branch redirects after the delay slot and flush redirects at once.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        br_flag,
    input  logic [31:0] br_addr,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_addr_ok,
    input  logic        ibus_data_ok,
    input  logic [31:0] ibus_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_pcp4,
    output logic [31:0] if_inst,
    output logic        fetch_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        br_pend_q, br_pend_d;
    logic [31:0] br_tgt_q, br_tgt_d;
    logic        dis_q, dis_d;
    logic [31:0] rd_pc_q, rd_pc_d;

    logic        avail;
    logic        handoff;
    logic        br_now;
    logic [31:0] next_pc;

    // An instruction is offered when one is buffered, or when live (not
    // discarded) data returns this cycle.
    assign avail   = (state_q == HOLD) ||
                     ((state_q == WAIT) && ibus_data_ok && !dis_q);
    assign handoff = avail && !stall && !flush;

    // A branch seen in ID in the same cycle as the delay-slot handoff must
    // still steer the next fetch, so the live request is forwarded ahead of
    // the registered pending target.
    assign br_now  = br_flag && !dis_q;
    assign next_pc = br_now    ? br_addr  :
                     br_pend_q ? br_tgt_q : (fpc_q + 32'd4);

    assign ibus_req    = (state_q == REQ);
    assign ibus_addr   = fpc_q;
    assign if_pc       = fpc_q;
    assign if_pcp4     = fpc_q + 32'd4;
    assign fetch_stall = !avail;

    // Offered instruction: buffered word in HOLD, bus data when live, else NOP.
    always_comb begin
        if_inst = 32'd0;
        if (state_q == HOLD) begin
            if_inst = inst_buf_q;
        end else if (avail) begin
            if_inst = ibus_rdata;
        end
    end

    // Next-state logic: flush first, then branch capture and normal fetch flow.
    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        inst_buf_d = inst_buf_q;
        br_pend_d  = br_pend_q;
        br_tgt_d   = br_tgt_q;
        dis_d      = dis_q;
        rd_pc_d    = rd_pc_q;

        if (flush) begin
            br_pend_d = 1'b0;
            unique case (state_q)
                IDLE, HOLD: begin
                    fpc_d   = flush_pc;
                    state_d = REQ;
                end
                REQ: begin
                    // Address stays on the bus until accepted; the answer
                    // to it is dropped later.
                    dis_d   = 1'b1;
                    rd_pc_d = flush_pc;
                    if (ibus_addr_ok) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (ibus_data_ok) begin
                        fpc_d   = flush_pc;
                        dis_d   = 1'b0;
                        state_d = REQ;
                    end else begin
                        dis_d   = 1'b1;
                        rd_pc_d = flush_pc;
                    end
                end
                default: ;
            endcase
        end else begin
            if (br_now) begin
                br_pend_d = 1'b1;
                br_tgt_d  = br_addr;
            end
            unique case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (ibus_addr_ok) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (ibus_data_ok) begin
                        if (dis_q) begin
                            fpc_d   = rd_pc_q;
                            dis_d   = 1'b0;
                            state_d = REQ;
                        end else if (handoff) begin
                            fpc_d     = next_pc;
                            br_pend_d = 1'b0;
                            state_d   = REQ;
                        end else begin
                            inst_buf_d = ibus_rdata;
                            state_d    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (handoff) begin
                        fpc_d     = next_pc;
                        br_pend_d = 1'b0;
                        state_d   = REQ;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control and PC state, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fpc_q      <= RESET_PC;
            inst_buf_q <= 32'd0;
            br_pend_q  <= 1'b0;
            dis_q      <= 1'b0;
            rd_pc_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            inst_buf_q <= inst_buf_d;
            br_pend_q  <= br_pend_d;
            dis_q      <= dis_d;
            rd_pc_q    <= rd_pc_d;
        end
    end

    // Branch target is only meaningful while br_pend_q is set; no reset needed.
    always_ff @(posedge clk) begin
        br_tgt_q <= br_tgt_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus a reset-in-WAIT
// sequence.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        br_flag;
    logic [31:0] br_addr;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_addr_ok;
    logic        ibus_data_ok;
    logic [31:0] ibus_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_pcp4;
    logic [31:0] if_inst;
    logic        fetch_stall;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .br_flag      (br_flag),
        .br_addr      (br_addr),
        .ibus_req     (ibus_req),
        .ibus_addr    (ibus_addr),
        .ibus_addr_ok (ibus_addr_ok),
        .ibus_data_ok (ibus_data_ok),
        .ibus_rdata   (ibus_rdata),
        .if_pc        (if_pc),
        .if_pcp4      (if_pcp4),
        .if_inst      (if_inst),
        .fetch_stall  (fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        fl;
        logic [31:0] fpc;
        logic        br;
        logic [31:0] ba;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
        logic        e_fs;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic fl, logic [31:0] fpc, logic br,
                                logic [31:0] ba, logic aok, logic dok, logic [31:0] rd,
                                logic e_req, logic [31:0] e_addr, logic [31:0] e_inst,
                                logic e_fs);
        vec_t v;
        v.st = st; v.fl = fl; v.fpc = fpc; v.br = br; v.ba = ba;
        v.aok = aok; v.dok = dok; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_inst = e_inst; v.e_fs = e_fs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic [31:0] e_inst, input logic e_fs);
        chk({tag, ".ibus_req"},    {31'd0, ibus_req},    {31'd0, e_req});
        chk({tag, ".ibus_addr"},   ibus_addr,            e_addr);
        chk({tag, ".if_pc"},       if_pc,                e_addr);
        chk({tag, ".if_pcp4"},     if_pcp4,              e_addr + 32'd4);
        chk({tag, ".if_inst"},     if_inst,              e_inst);
        chk({tag, ".fetch_stall"}, {31'd0, fetch_stall}, {31'd0, e_fs});
    endtask

    task automatic drive_idle();
        stall = 0; flush = 0; flush_pc = 0; br_flag = 0; br_addr = 0;
        ibus_addr_ok = 0; ibus_data_ok = 0; ibus_rdata = 0;
    endtask

    initial begin
        //          st fl fpc           br ba            aok dok rdata          req addr          inst           fs
        // zero-wait sequential fetch
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'hBFC00000, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC00000, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h11111111, 0, 32'hBFC00000, 32'h11111111, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC00004, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h22222222, 0, 32'hBFC00004, 32'h22222222, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC00008, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h33333333, 0, 32'hBFC00008, 32'h33333333, 0));
        // stall on data return -> HOLD for 3 cycles
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC0000C, 32'h0,        1));
        vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h24010001, 0, 32'hBFC0000C, 32'h24010001, 0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        0, 32'hBFC0000C, 32'h24010001, 0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        0, 32'hBFC0000C, 32'h24010001, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'hBFC0000C, 32'h24010001, 0));
        // addr_ok wait state, then branch while delay slot is in WAIT
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'hBFC00010, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC00010, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h80001000, 0, 0, 32'h0,        0, 32'hBFC00010, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h3C1D0000, 0, 32'hBFC00010, 32'h3C1D0000, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h80001000, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h44444444, 0, 32'h80001000, 32'h44444444, 0));
        // flush in WAIT, data two cycles later is dropped
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h80001004, 32'h0,        1));
        vecs.push_back(mk(0, 1, 32'hBFC00380, 0, 32'h0,        0, 0, 32'h0,        0, 32'h80001004, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h80001004, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h80001004, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC00380, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h55555555, 0, 32'hBFC00380, 32'h55555555, 0));
        // flush in REQ with addr_ok low for 2 cycles
        vecs.push_back(mk(0, 1, 32'h00000100, 0, 32'h0,        0, 0, 32'h0,        1, 32'hBFC00384, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'hBFC00384, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC00384, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h66666666, 0, 32'hBFC00384, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h00000100, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h77777777, 0, 32'h00000100, 32'h77777777, 0));
        // flush from HOLD to top of address space, then PC wraps to 0
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h00000104, 32'h0,        1));
        vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h88888888, 0, 32'h00000104, 32'h88888888, 0));
        vecs.push_back(mk(1, 1, 32'hFFFFFFFC, 0, 32'h0,        0, 0, 32'h0,        0, 32'h00000104, 32'h88888888, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hFFFFFFFC, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h99999999, 0, 32'hFFFFFFFC, 32'h99999999, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h00000000, 32'h0,        1));
        // branch ignored under flush and while discarding
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h00000000, 32'h0,        1));
        vecs.push_back(mk(0, 1, 32'h00000200, 1, 32'h12345678, 0, 0, 32'h0,        0, 32'h00000000, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h12345678, 0, 1, 32'hAAAAAAAA, 0, 32'h00000000, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h00000200, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hBBBBBBBB, 0, 32'h00000200, 32'hBBBBBBBB, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h00000204, 32'h0,        1));
        // flush in WAIT coinciding with data_ok: data dropped, refetch at target
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h00000204, 32'h0,        1));
        vecs.push_back(mk(0, 1, 32'h00000300, 0, 32'h0,        0, 1, 32'hCCCCCCCC, 0, 32'h00000204, 32'hCCCCCCCC, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h00000300, 32'h0,        1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'h00000300, 32'h0,        1));

        // Reset state
        drive_idle();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk_all("reset", 1'b0, 32'hBFC00000, 32'h0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table: inputs applied just after a rising edge, outputs sampled on the falling edge
        for (int i = 0; i < vecs.size(); i++) begin
            stall        = vecs[i].st;
            flush        = vecs[i].fl;
            flush_pc     = vecs[i].fpc;
            br_flag      = vecs[i].br;
            br_addr      = vecs[i].ba;
            ibus_addr_ok = vecs[i].aok;
            ibus_data_ok = vecs[i].dok;
            ibus_rdata   = vecs[i].rd;
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                    vecs[i].e_inst, vecs[i].e_fs);
            @(posedge clk);
            #1;
        end

        // Reset asserted while a request is in WAIT
        drive_idle();
        rst = 1'b1;
        #1;
        chk_all("rst_mid_wait", 1'b0, 32'hBFC00000, 32'h0, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all("post_rst_idle", 1'b0, 32'hBFC00000, 32'h0, 1'b1);
        @(posedge clk);
        #1 ibus_addr_ok = 1'b1;
        @(negedge clk);
        chk_all("post_rst_req", 1'b1, 32'hBFC00000, 32'h0, 1'b1);
        @(posedge clk);
        #1 drive_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the MangoMIPS32 five-stage pipeline.
- Owns the PC and drives an SRAM-like instruction bus with a req/addr_ok/data_ok handshake.
- Presents if_pc, if_pcp4 and if_inst to the IF/ID pipeline register directly downstream.
- Applies ID-stage branch redirects after the delay slot, applies exception/ERET flush redirects immediately, and raises a stall request while no instruction is available.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  IF/ID hold from the pipeline controller; when high, the stage must not hand off an instruction.
- flush  in  1  exception/ERET redirect; takes priority over everything except rst.
- flush_pc  in  32  redirect target, valid with flush.
- br_flag  in  1  ID holds a taken branch/jump.
- br_addr  in  32  branch target, valid with br_flag.
- ibus_req  out  1  bus request.
- ibus_addr  out  32  request address.
- ibus_addr_ok  in  1  address accepted this cycle.
- ibus_data_ok  in  1  read data valid this cycle.
- ibus_rdata  in  32  instruction word.
- if_pc  out  32  PC of the offered instruction.
- if_pcp4  out  32  if_pc+4, modulo 2^32.
- if_inst  out  32  offered instruction; 0 (NOP) when none is available.
- fetch_stall  out  1  stall request to the pipeline controller.

Behaviour:
- Registers: state, fpc, inst_buf, br_pend, br_tgt, dis, rd_pc.
- States: IDLE, REQ, WAIT, HOLD.
- Reset (async): state=IDLE, fpc=RESET_PC, inst_buf=0, br_pend=0, dis=0, rd_pc=0.
- Outputs during reset: ibus_req=0, if_pc=RESET_PC, if_pcp4=RESET_PC+4, if_inst=0, fetch_stall=1.
- IDLE -> REQ unconditionally on the first clock after reset release.
- Combinational outputs:
  - ibus_req = (state==REQ).
  - ibus_addr = if_pc = fpc.
  - ibus_addr is held stable while ibus_req=1 and ibus_addr_ok=0.
- Data ready: avail = (state==HOLD) | (state==WAIT & ibus_data_ok & !dis).
- if_inst = inst_buf in HOLD; ibus_rdata when avail in WAIT; else 0.
- fetch_stall = !avail.
- Handoff = avail & !stall & !flush.
  - On handoff: fpc <= br_pend ? br_tgt : fpc+4; br_pend <= 0; state <= REQ.
  - Zero-wait bus gives one instruction per 2 cycles (REQ, WAIT), plus addr_ok/data_ok wait states.
- Normal transitions:
  - REQ & addr_ok -> WAIT.
  - WAIT & data_ok & !dis & stall -> HOLD, inst_buf <= ibus_rdata.
  - HOLD stays until handoff.
- Branch capture: while br_flag=1 and not flushing, br_pend <= 1 and br_tgt <= br_addr.
  - The instruction currently in flight or held is the delay slot: it is delivered, never discarded.
  - br_flag held high across stall cycles recaptures the same target, which is harmless.
- Flush, by state:
  - HOLD or IDLE: fpc <= flush_pc, state <= REQ, next cycle.
  - REQ & !addr_ok: dis <= 1, rd_pc <= flush_pc; stay in REQ with the old address.
  - REQ & addr_ok: dis <= 1, rd_pc <= flush_pc, -> WAIT.
  - WAIT & !data_ok: dis <= 1, rd_pc <= flush_pc.
  - WAIT & data_ok: drop the data; fpc <= flush_pc, dis <= 0, -> REQ.
  - In every case br_pend <= 0.
  - A later flush while dis=1 overwrites rd_pc (latest wins).
- Discard: WAIT & data_ok & dis -> fpc <= rd_pc, dis <= 0, -> REQ; fetch_stall stays 1.
- br_flag is ignored while flush=1 or dis=1.
- PC arithmetic wraps: 32'hFFFF_FFFC + 4 = 0.
- No alignment check in this block.

Test Plan:
- Reset, then zero-wait bus (addr_ok in REQ, data_ok in the following WAIT cycle) -> ibus_addr BFC00000, BFC00004, BFC00008; fetch_stall low every second cycle; if_pcp4 = if_pc+4.
- stall=1 for 3 cycles when data_ok arrives with rdata 0x24010001 -> HOLD; if_inst stays 0x24010001, if_pc constant, no new ibus_req; after stall drops, next ibus_addr = old+4.
- br_flag=1, br_addr=0x80001000 while delay slot at 0xBFC00010 is in WAIT -> delay-slot instruction delivered; next ibus_addr=0x80001000.
- flush with flush_pc=0xBFC00380 in WAIT, data_ok two cycles later -> that data never appears on if_inst (fetch_stall=1); next ibus_addr=0xBFC00380.
- flush in REQ with addr_ok held low 2 cycles -> ibus_addr stays the old value until accepted; response dropped; then a fetch at flush_pc.
- rst asserted mid-WAIT -> ibus_req=0 immediately; after release one IDLE cycle, then ibus_addr=RESET_PC.
